// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory programmer.
// Takes a little-endian byte stream (LEN_LO, LEN_HI, then 4*N data bytes) over
// a valid/ready handshake and writes each data byte to the instruction memory
// at consecutive byte addresses from 0. Core_Hold keeps the core stalled until
// a complete, legal image has been written.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing byte
// equal to the XOR of all data bytes before the load is declared done.
module imem_loader #(
    parameter int MEM_BYTES = 160,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              Start,
    input  logic [7:0]        Byte_In,
    input  logic              Byte_Valid,
    output logic              Byte_Ready,
    output logic              Wr_En,
    output logic [ADDR_W-1:0] Wr_Address,
    output logic [7:0]        Wr_Data,
    output logic              Core_Hold,
    output logic              Load_Done,
    output logic              Load_Error
);

    localparam logic [15:0] MAX_WORDS = 16'(MEM_BYTES / 4);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERR
    } state_t;
    // Every path that finishes the data goes through the checksum byte first.
    localparam state_t S_FINAL = S_CHECK;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERR
    } state_t;
    localparam state_t S_FINAL = S_DONE;
`endif

    state_t            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       n_q, n_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              hold_q, hold_d;
    logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              accept;
    logic [15:0]       n_full;
    logic              last_data;

    // Byte_Ready depends on the state alone, so it is stable for a whole cycle.
    always_comb begin
        Byte_Ready = 1'b0;
        case (state_q)
            S_LEN_LO, S_LEN_HI, S_DATA: Byte_Ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK:                    Byte_Ready = 1'b1;
`endif
            default:                    Byte_Ready = 1'b0;
        endcase
    end

    assign accept    = Byte_Valid && Byte_Ready;
    assign n_full    = {Byte_In, len_lo_q};
    // The byte counter never wraps: N is capped at MEM_BYTES/4 before DATA.
    assign last_data = (cnt_q + ADDR_W'(1)) == ADDR_W'({n_q, 2'b00});

    assign Wr_En      = wr_en_q;
    assign Wr_Address = wr_addr_q;
    assign Wr_Data    = wr_data_q;
    assign Core_Hold  = hold_q;
    assign Load_Done  = (state_q == S_DONE);
    assign Load_Error = err_q;

    // Next-state and registered-output logic for the load session.
    always_comb begin
        state_d   = state_q;
        len_lo_d  = len_lo_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        hold_d    = hold_q;
        err_d     = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (Start) begin
                    state_d = S_LEN_LO;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                    hold_d  = 1'b0;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_lo_d = Byte_In;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    n_d = n_full;
                    if (n_full > MAX_WORDS) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (n_full == 16'd0) begin
                        state_d = S_FINAL;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = Byte_In;
                    cnt_d     = cnt_q + ADDR_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d    = csum_q ^ Byte_In;
`endif
                    if (last_data) begin
                        state_d = S_FINAL;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    if (Byte_In == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset leaves the core stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            len_lo_q  <= 8'h00;
            n_q       <= 16'h0000;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            hold_q    <= 1'b1;
            err_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            len_lo_q  <= len_lo_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed streams, a byte-position model of the
// loader compared against the DUT every cycle, plus literal spot checks.
module tb_imem_loader;

    localparam int MEM_BYTES = 160;
    localparam int ADDR_W    = 64;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              Start;
    logic [7:0]        Byte_In;
    logic              Byte_Valid;
    logic              Byte_Ready;
    logic              Wr_En;
    logic [ADDR_W-1:0] Wr_Address;
    logic [7:0]        Wr_Data;
    logic              Core_Hold;
    logic              Load_Done;
    logic              Load_Error;

    always #5 clk = ~clk;

    imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Start      (Start),
        .Byte_In    (Byte_In),
        .Byte_Valid (Byte_Valid),
        .Byte_Ready (Byte_Ready),
        .Wr_En      (Wr_En),
        .Wr_Address (Wr_Address),
        .Wr_Data    (Wr_Data),
        .Core_Hold  (Core_Hold),
        .Load_Done  (Load_Done),
        .Load_Error (Load_Error)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: tracks position in the current session's byte stream.
    bit         model_on = 1'b0;
    bit         m_busy, m_wr_en, m_done, m_err, m_hold, m_was_done;
    int         m_cnt, m_n, m_i;
    logic [7:0] m_x, m_b, m_data;
    logic [63:0] m_addr;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_busy = 0; m_wr_en = 0; m_done = 0; m_err = 0; m_hold = 1;
            m_cnt = 0; m_n = 0; m_x = 8'h00; m_addr = 0; m_data = 8'h00;
        end else begin
            m_was_done = m_done;
            m_wr_en = 0;
            m_done  = 0;
            if (!m_busy) begin
                if (Start) begin
                    m_busy = 1; m_cnt = 0; m_x = 8'h00; m_err = 0; m_hold = 1;
                end else if (m_was_done) begin
                    m_hold = 0;
                end
            end else if (Byte_Valid) begin
                m_b = Byte_In;
                m_i = m_cnt;
                m_cnt++;
                if (m_i == 0) begin
                    m_n = int'(m_b);
                end else if (m_i == 1) begin
                    m_n = m_n + 256 * int'(m_b);
                    if (m_n > MEM_BYTES / 4) begin
                        m_busy = 0; m_err = 1;
                    end else if (m_n == 0) begin
`ifndef IMEM_LOADER_CHECKSUM_EN
                        m_busy = 0; m_done = 1;
`endif
                    end
                end else if (m_i < 2 + 4 * m_n) begin
                    m_wr_en = 1;
                    m_addr  = 64'(m_i - 2);
                    m_data  = m_b;
                    m_x     = m_x ^ m_b;
                    if (m_i == 4 * m_n + 1) begin
`ifndef IMEM_LOADER_CHECKSUM_EN
                        m_busy = 0; m_done = 1;
`endif
                    end
                end else begin
                    m_busy = 0;
                    if (m_b == m_x) m_done = 1;
                    else            m_err  = 1;
                end
            end
        end
    end

    // Compare DUT against the model every cycle, mid-cycle.
    initial forever begin
        @(negedge clk);
        if (model_on) begin
            chk("ready", Byte_Ready, m_busy);
            chk("wr_en", Wr_En, m_wr_en);
            if (m_wr_en) begin
                chk("wr_addr", Wr_Address, m_addr);
                chk("wr_data", Wr_Data, m_data);
            end
            chk("load_done", Load_Done, m_done);
            chk("load_error", Load_Error, m_err);
            chk("core_hold", Core_Hold, m_hold);
        end
    end

    // Bench-side image of the instruction memory and event counters.
    logic [7:0]  tb_mem [0:255];
    int          n_writes, done_cnt;
    logic [63:0] last_addr;

    initial forever begin
        @(negedge clk);
        if (reset_n === 1'b1) begin
            if (Wr_En) begin
                tb_mem[Wr_Address[7:0]] = Wr_Data;
                n_writes++;
                last_addr = Wr_Address;
            end
            if (Load_Done) done_cnt++;
        end
    end

    logic [7:0] stream [$];

    task automatic clear_log();
        for (int k = 0; k < 256; k++) tb_mem[k] = 8'hEE;
        n_writes  = 0;
        done_cnt  = 0;
        last_addr = '1;
    endtask

    task automatic add_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int k = 2; k < stream.size(); k++) x = x ^ stream[k];
        stream.push_back(x);
`endif
    endtask

    task automatic pulse_start();
        @(negedge clk);
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit gaps);
        int  tries;
        bit  taken;
        tries = 0;
        taken = 0;
        while (!taken && tries < 64) begin
            if (tries > 0 || 1'b1) @(negedge clk);
            tries++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                Byte_Valid = 1'b0;
                Byte_In    = 8'($urandom);
            end else begin
                Byte_Valid = 1'b1;
                Byte_In    = b;
                if (Byte_Ready) begin
                    taken = 1;
                    @(posedge clk);
                end
            end
        end
        if (!taken) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send(input int count, input bit gaps);
        for (int k = 0; k < count; k++) drive_byte(stream[k], gaps);
    endtask

    // First negedge after the final accepted byte: Load_Done must be up now.
    task automatic finish(input string name, input logic exp_done);
        @(negedge clk);
        Byte_Valid = 1'b0;
        chk(name, Load_Done, exp_done);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_t1();
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h80, 8'h02};
        add_csum();
    endtask

    task automatic check_t1(input string tag);
        chk({tag, "_nwrites"}, 64'(n_writes), 64'd8);
        chk({tag, "_mem0"}, tb_mem[0], 8'h13);
        chk({tag, "_mem3"}, tb_mem[3], 8'h00);
        chk({tag, "_mem4"}, tb_mem[4], 8'h93);
        chk({tag, "_mem7"}, tb_mem[7], 8'h02);
        chk({tag, "_mem8"}, tb_mem[8], 8'hEE);
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, "_hold"}, Core_Hold, 1'b0);
    endtask

    initial begin
        reset_n    = 1'b0;
        Start      = 1'b0;
        Byte_Valid = 1'b0;
        Byte_In    = 8'h00;
        clear_log();
        idle(3);
        chk("rst_ready", Byte_Ready, 1'b0);
        chk("rst_wr_en", Wr_En, 1'b0);
        chk("rst_addr", Wr_Address, 64'd0);
        chk("rst_data", Wr_Data, 8'h00);
        chk("rst_hold", Core_Hold, 1'b1);
        chk("rst_done", Load_Done, 1'b0);
        chk("rst_err", Load_Error, 1'b0);
        #2 reset_n = 1'b1;
        model_on = 1'b1;
        idle(2);

        // Two-word image, full throughput.
        clear_log();
        load_t1();
        pulse_start();
        send(stream.size(), 1'b0);
        finish("t1_done_timing", 1'b1);
        idle(4);
        check_t1("t1");

        // Largest legal image: 40 words, 160 bytes.
        clear_log();
        stream = '{8'h28, 8'h00};
        for (int k = 0; k < 160; k++) stream.push_back(8'(k * 7 + 3));
        add_csum();
        pulse_start();
        send(stream.size(), 1'b0);
        finish("t2_done_timing", 1'b1);
        idle(4);
        chk("t2_last_addr", last_addr, 64'd159);
        chk("t2_nwrites", 64'(n_writes), 64'd160);
        chk("t2_mem159", tb_mem[159], 8'h5C);
        chk("t2_mem0", tb_mem[0], 8'h03);
        chk("t2_done_cnt", 64'(done_cnt), 64'd1);

        // One word too many: error after LEN_HI, nothing further consumed.
        clear_log();
        stream = '{8'h29, 8'h00};
        pulse_start();
        send(2, 1'b0);
        finish("t3_no_done", 1'b0);
        Byte_Valid = 1'b1;
        Byte_In    = 8'hAA;
        idle(5);
        Byte_Valid = 1'b0;
        chk("t3_err", Load_Error, 1'b1);
        chk("t3_hold", Core_Hold, 1'b1);
        chk("t3_ready", Byte_Ready, 1'b0);
        chk("t3_nwrites", 64'(n_writes), 64'd0);
        chk("t3_done_cnt", 64'(done_cnt), 64'd0);

        // Same image with random gaps in Byte_Valid; Start also clears the error.
        clear_log();
        load_t1();
        pulse_start();
        chk("t4_err_cleared", Load_Error, 1'b0);
        send(stream.size(), 1'b1);
        finish("t4_done_timing", 1'b1);
        idle(4);
        check_t1("t4");

        // Reset in the middle of the data phase, then a clean reload.
        clear_log();
        load_t1();
        pulse_start();
        send(5, 1'b0);
        @(negedge clk);
        Byte_Valid = 1'b0;
        chk("t5_pre_wr_en", Wr_En, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_ready", Byte_Ready, 1'b0);
        chk("t5_rst_wr_en", Wr_En, 1'b0);
        chk("t5_rst_addr", Wr_Address, 64'd0);
        chk("t5_rst_data", Wr_Data, 8'h00);
        chk("t5_rst_hold", Core_Hold, 1'b1);
        chk("t5_rst_done", Load_Done, 1'b0);
        chk("t5_rst_err", Load_Error, 1'b0);
        idle(2);
        #2 reset_n = 1'b1;
        idle(2);
        clear_log();
        pulse_start();
        send(stream.size(), 1'b0);
        finish("t5_done_timing", 1'b1);
        idle(4);
        check_t1("t5");

        // Zero-length image: done right after the length (or checksum 00).
        clear_log();
        stream = '{8'h00, 8'h00};
        add_csum();
        pulse_start();
        send(stream.size(), 1'b0);
        finish("t6_done_timing", 1'b1);
        idle(3);
        chk("t6_nwrites", 64'(n_writes), 64'd0);
        chk("t6_done_cnt", 64'(done_cnt), 64'd1);
        chk("t6_hold", Core_Hold, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch on a one-word image.
        clear_log();
        stream = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h46};
        pulse_start();
        send(stream.size(), 1'b0);
        finish("t7_good_done", 1'b1);
        idle(3);
        chk("t7_good_err", Load_Error, 1'b0);
        chk("t7_good_hold", Core_Hold, 1'b0);
        clear_log();
        stream = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h47};
        pulse_start();
        send(stream.size(), 1'b0);
        finish("t7_bad_no_done", 1'b0);
        idle(3);
        chk("t7_bad_err", Load_Error, 1'b1);
        chk("t7_bad_hold", Core_Hold, 1'b1);
        chk("t7_bad_nwrites", 64'(n_writes), 64'd4);
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time programmer for the instruction memory. It accepts a little-endian byte stream over a valid/ready handshake and emits byte writes into the byte-addressed instruction memory, in the same byte order the fetch path reads: byte at address A is bits [7:0] of the word at A. It holds the core in a stall state until a complete, legal image has been written. It sits between the host/debug byte source and the instruction memory's write port.

## Interface
- MEM_BYTES, 160: instruction memory size in bytes; must be a multiple of 4.
- ADDR_W, 64: width of the write address, matching the fetch address width.

- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  begins a load session; sampled only in IDLE, DONE or ERR.
- Byte_In  in  8  stream byte.
- Byte_Valid  in  1  Byte_In is valid.
- Byte_Ready  out  1  loader can accept a byte. A byte transfers at a rising edge with Byte_Valid && Byte_Ready.
- Wr_En  out  1  one-cycle byte write strobe to the instruction memory.
- Wr_Address  out  ADDR_W  byte address of the write.
- Wr_Data  out  8  byte to write.
- Core_Hold  out  1  stalls PC/fetch while high.
- Load_Done  out  1  one-cycle pulse on successful completion.
- Load_Error  out  1  sticky error flag; cleared by Start or reset.

## Operation
- Stream format:
  - LEN_LO byte, then LEN_HI byte. Together they form the 16-bit word count N.
  - Then 4*N data bytes, written to addresses 0 .. 4N-1 in arrival order.
  - With checksum enabled, one trailing checksum byte follows the data.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK (macro only), DONE, ERR.
- Transitions:
  - IDLE/DONE/ERR with Start=1 -> LEN_LO. Load_Error clears and the byte counter is set to 0.
  - LEN_LO: accepted byte -> LEN_HI.
  - LEN_HI: accepted byte. If N > MEM_BYTES/4 -> ERR. If N == 0 -> CHECK (macro) or DONE. Otherwise -> DATA.
  - DATA: each accepted byte increments the counter. The byte whose counter value is 4N-1 -> CHECK (macro) or DONE.
  - DONE: after one cycle -> IDLE, unless Start=1, which goes to LEN_LO.
- Start is ignored in LEN_LO, LEN_HI, DATA and CHECK.
- Byte_Ready is 1 in LEN_LO, LEN_HI, DATA and CHECK, and 0 otherwise. Bytes offered in other states are not consumed.
- Core_Hold:
  - Goes to 1 on entry to LEN_LO.
  - Goes to 0 only on the clock edge leaving DONE.
  - Stays 1 in ERR.
- The byte counter is ADDR_W-wide, zero-extended onto Wr_Address. It cannot wrap, because N is bounded by the length check.
- Memory contents already written are never rolled back on error or reset.

## Timing
- Reset values:
  - State IDLE.
  - Byte_Ready=0, Wr_En=0, Wr_Address=0, Wr_Data=0.
  - Core_Hold=1. The core stays stalled until the first successful load.
  - Load_Done=0, Load_Error=0.
- Write latency is 1 cycle. A data byte accepted at edge k gives Wr_En=1 with its Wr_Address and Wr_Data in the cycle after edge k. Wr_En is 0 in the following cycle unless another byte was accepted at edge k+1.
- Full throughput: with Byte_Valid held at 1, one byte transfers per cycle. Gaps in Byte_Valid insert idle cycles but change no state.
- Completion:
  - The final accepting byte at edge k (last data byte, checksum byte, or LEN_HI when N=0) puts the state in DONE for cycle k+1.
  - In cycle k+1, Load_Done=1 and the final Wr_En is also 1 when that byte was data.
  - Core_Hold drops after edge k+1.
- Error: Load_Error rises in the cycle after the offending byte and holds until Start.
- Asynchronous reset during any state immediately forces all reset values. Any partially accepted stream is discarded.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - CHECK state exists. The loader accepts one byte equal to the XOR of all 4N data bytes (0x00 when N=0).
  - On a match -> DONE. On a mismatch -> ERR, with Load_Error=1 and Core_Hold=1.
- Not defined: no CHECK state, no checksum byte. DATA or LEN_HI go directly to DONE.

## Test plan
- Reset, then Start, then stream 02 00 13 05 50 00 93 05 80 02 -> eight writes at addresses 0..7 with data 13,05,50,00,93,05,80,02. Load_Done pulses once, then Core_Hold=0.
- MEM_BYTES=160, length 28 00 (N=40), then 160 bytes -> last write Wr_Address=159, Load_Done=1. Repeat with length 29 00 -> Load_Error=1, no writes, Core_Hold=1, Byte_Ready=0.
- Same 2-word image with Byte_Valid toggled randomly -> identical write sequence. Every Wr_En is exactly one cycle after its accepting edge.
- reset_n asserted low after the 3rd data byte -> all outputs return to reset values at once. A following Start with a full stream completes normally from address 0.
- With IMEM_LOADER_CHECKSUM_EN: 01 00 13 05 50 00 then checksum 46 -> Load_Done=1. The same stream with checksum 47 -> Load_Error=1 and Core_Hold=1.
- Length 00 00 -> no writes. Load_Done is asserted the cycle after LEN_HI is accepted (after the checksum byte 00 with the macro defined).
